pwl_tx_driver: RTL

PWL_TX_DRIVER -- requirements
Module: pwl_tx_driver

---
 rtl/pwl_tx_pkg.sv | 28 ++
 rtl/pwl_tx_fifo.sv | 70 +++++++
 rtl/pwl_tx_driver.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pwl_tx_pkg.sv
// -----------------------------------------------------------------------------
// pwl_tx_pkg
// Shared types for the piecewise-linear TX driver.
//   pwl_state_t : segment FSM states (IDLE / RAMP / FLAT)
//   pwl_seg_t   : one PWL segment {a = start level, b = slope per cycle,
//                 dur = length in cycles}
//   PWL_DW      : signed width of the level/slope fields. The driver's DW
//                 parameter must equal this value; change it here to build a
//                 wider datapath.
// -----------------------------------------------------------------------------
package pwl_tx_pkg;

   localparam int PWL_DW  = 16;
   localparam int DUR_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_FLAT = 2'd2
   } pwl_state_t;

   typedef struct packed {
      logic signed [PWL_DW-1:0] a;
      logic signed [PWL_DW-1:0] b;
      logic [DUR_W-1:0]         dur;
   } pwl_seg_t;

endpackage

// File: rtl/pwl_tx_fifo.sv
// -----------------------------------------------------------------------------
// pwl_tx_fifo
// Small first-word-fall-through FIFO holding the TX data bits.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter.
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset (pointers only)
//   i_wr_en     : write request; ignored while full
//   i_wr_data   : bit to store
//   i_rd_en     : pop request; ignored while empty
//   o_rd_data   : head-of-queue bit (valid while !o_empty)
//   o_full      : no room for another bit
//   o_empty     : nothing stored
// -----------------------------------------------------------------------------
module pwl_tx_fifo
   import pwl_tx_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic clk,
   input  logic rstn,
   input  logic i_wr_en,
   input  logic i_wr_data,
   input  logic i_rd_en,
   output logic o_rd_data,
   output logic o_full,
   output logic o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   logic        r_mem [DEPTH];

   logic        w_wr_fire;
   logic        w_rd_fire;

   // A pop while empty is dropped, so a same-cycle push never bypasses
   // storage; a push while full is dropped as well.
   assign w_wr_fire = i_wr_en && !o_full;
   assign w_rd_fire = i_rd_en && !o_empty;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_rd_fire) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
      end
   end

   // Storage needs no reset: stale entries are unreachable while empty.
   always_ff @(posedge clk) begin
      if (w_wr_fire) begin
         r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/pwl_tx_driver.sv
// -----------------------------------------------------------------------------
// pwl_tx_driver
// Converts a serial TX bit stream into piecewise-linear (PWL) segments for a
// waveform consumer. Each bit becomes either a ramp followed by a flat
// segment (level change) or one flat segment spanning the whole UI.
//
// Optional feature (compile-time macro):
//   PWL_TX_DEEMPH_EN : 2-tap de-emphasis, target = s(n)*VSWING - s(n-1)*W1,
//                      saturated to DW. Undefined (default): target =
//                      s(n)*VSWING and no previous-bit state exists.
//
// Ports:
//   clk        : clock
//   rstn       : asynchronous active-low reset
//   din        : TX data bit
//   din_valid  : din offered
//   din_ready  : bit FIFO can accept (not full)
//   pwl_a      : segment start level (signed DW)
//   pwl_b      : segment slope per cycle (signed DW)
//   pwl_dur    : segment length in cycles
//   pwl_valid  : segment valid (RAMP/FLAT states)
//   pwl_ready  : consumer accepts segment
//   busy       : FIFO non-empty or segment pending
// -----------------------------------------------------------------------------
module pwl_tx_driver
   import pwl_tx_pkg::*;
#(
   parameter int DW         = 16,
   parameter int VSWING     = 8192,
   parameter int UI_CYC     = 16,
   parameter int RAMP_CYC   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int W1         = 2048
)(
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 din,
   input  logic                 din_valid,
   output logic                 din_ready,
   output logic signed [DW-1:0] pwl_a,
   output logic signed [DW-1:0] pwl_b,
   output logic [7:0]           pwl_dur,
   output logic                 pwl_valid,
   input  logic                 pwl_ready,
   output logic                 busy
);

   localparam int RAMP_SH = $clog2(RAMP_CYC);
   localparam int SAT_MAX = (2 ** (DW - 1)) - 1;
   localparam int SAT_MIN = -(2 ** (DW - 1));

   localparam logic signed [DW:0] SLOPE_MAX = (DW+1)'(SAT_MAX);
   localparam logic signed [DW:0] SLOPE_MIN = (DW+1)'(SAT_MIN);

   localparam logic [7:0] DUR_RAMP = 8'(RAMP_CYC);
   localparam logic [7:0] DUR_UI   = 8'(UI_CYC);
   localparam logic [7:0] DUR_TAIL = 8'(UI_CYC - RAMP_CYC);

   // Elaboration-time parameter sanity.
   if (DW != PWL_DW) begin : g_chk_dw
      $error("pwl_tx_driver: DW must equal pwl_tx_pkg::PWL_DW");
   end
   if (((RAMP_CYC & (RAMP_CYC - 1)) != 0) || (RAMP_CYC >= UI_CYC)) begin : g_chk_ramp
      $error("pwl_tx_driver: RAMP_CYC must be a power of two below UI_CYC");
   end
   if ((UI_CYC > 255) || (FIFO_DEPTH < 2) ||
       ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_sizes
      $error("pwl_tx_driver: UI_CYC must fit 8 bits, FIFO_DEPTH a power of two >= 2");
   end
   if (W1 < 0) begin : g_chk_w1
      $error("pwl_tx_driver: W1 must be non-negative");
   end

   // ---------------------------------------------------------------- state
   pwl_state_t           r_state;
   pwl_state_t           w_state_next;
   pwl_seg_t             r_seg;
   pwl_seg_t             w_seg_next;
   logic signed [DW-1:0] r_cur_level;
   logic signed [DW-1:0] w_cur_next;
   logic signed [DW-1:0] r_target;
   logic signed [DW-1:0] w_target_next;

   // ------------------------------------------------------------- datapath
   logic                 w_fifo_bit;
   logic                 w_fifo_empty;
   logic                 w_fifo_full;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_hs;
   logic signed [DW-1:0] w_base_level;
   int                   w_tgt_raw;
   int                   w_tgt_sat;
   logic signed [DW-1:0] w_new_tgt;
   logic signed [DW:0]   w_diff;
   logic signed [DW:0]   w_slope_wide;
   logic signed [DW-1:0] w_slope;
   logic                 w_need_ramp;

   // ------------------------------------------------------------ bit FIFO
   assign din_ready = !w_fifo_full;
   assign w_push    = din_valid && din_ready;

   pwl_tx_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .i_wr_en   (w_push),
      .i_wr_data (din),
      .i_rd_en   (w_pop),
      .o_rd_data (w_fifo_bit),
      .o_full    (w_fifo_full),
      .o_empty   (w_fifo_empty)
   );

   // ------------------------------------------------- target level for head
`ifdef PWL_TX_DEEMPH_EN
   logic r_prev_bit;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_prev_bit <= 1'b0;
      end else if (w_pop) begin
         r_prev_bit <= w_fifo_bit;
      end
   end

   always_comb begin
      w_tgt_raw = (w_fifo_bit ? VSWING : -VSWING) - (r_prev_bit ? W1 : -W1);
   end
`else
   always_comb begin
      w_tgt_raw = w_fifo_bit ? VSWING : -VSWING;
   end
`endif

   always_comb begin
      if (w_tgt_raw > SAT_MAX) begin
         w_tgt_sat = SAT_MAX;
      end else if (w_tgt_raw < SAT_MIN) begin
         w_tgt_sat = SAT_MIN;
      end else begin
         w_tgt_sat = w_tgt_raw;
      end
      w_new_tgt = w_tgt_sat[DW-1:0];
   end

   // When a bit is popped out of FLAT, the running level is the target that
   // FLAT is completing, not the not-yet-updated r_cur_level.
   assign w_base_level = (r_state == ST_FLAT) ? r_target : r_cur_level;

   // Difference at DW+1 bits so full-scale swings never wrap, then
   // arithmetic shift by log2(RAMP_CYC) and clamp back to DW.
   always_comb begin
      w_diff       = {w_new_tgt[DW-1], w_new_tgt} - {w_base_level[DW-1], w_base_level};
      w_slope_wide = w_diff >>> RAMP_SH;
      if (w_slope_wide > SLOPE_MAX) begin
         w_slope = SLOPE_MAX[DW-1:0];
      end else if (w_slope_wide < SLOPE_MIN) begin
         w_slope = SLOPE_MIN[DW-1:0];
      end else begin
         w_slope = w_slope_wide[DW-1:0];
      end
      w_need_ramp = (w_new_tgt != w_base_level);
   end

   // -------------------------------------------- FSM: state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_seg       <= '0;
         r_cur_level <= '0;
         r_target    <= '0;
      end else begin
         r_state     <= w_state_next;
         r_seg       <= w_seg_next;
         r_cur_level <= w_cur_next;
         r_target    <= w_target_next;
      end
   end

   // -------------------------------------------- FSM: next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_state_next = w_need_ramp ? ST_RAMP : ST_FLAT;
            end
         end
         ST_RAMP: begin
            if (w_hs) begin
               w_state_next = ST_FLAT;
            end
         end
         ST_FLAT: begin
            if (w_hs) begin
               if (!w_fifo_empty) begin
                  w_state_next = w_need_ramp ? ST_RAMP : ST_FLAT;
               end else begin
                  w_state_next = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------- FSM: outputs / segment load
   always_comb begin
      pwl_valid     = (r_state == ST_RAMP) || (r_state == ST_FLAT);
      w_hs          = pwl_valid && pwl_ready;
      busy          = !w_fifo_empty || pwl_valid;
      w_pop         = !w_fifo_empty &&
                      ((r_state == ST_IDLE) || ((r_state == ST_FLAT) && w_hs));

      w_seg_next    = r_seg;
      w_target_next = r_target;
      w_cur_next    = r_cur_level;

      if ((r_state == ST_FLAT) && w_hs) begin
         w_cur_next = r_target;
      end

      if (w_pop) begin
         w_target_next = w_new_tgt;
         if (w_need_ramp) begin
            w_seg_next.a   = w_base_level;
            w_seg_next.b   = w_slope;
            w_seg_next.dur = DUR_RAMP;
         end else begin
            w_seg_next.a   = w_new_tgt;
            w_seg_next.b   = '0;
            w_seg_next.dur = DUR_UI;
         end
      end else if ((r_state == ST_RAMP) && w_hs) begin
         // Ramp consumed: the rest of the UI sits flat at the target.
         w_seg_next.a   = r_target;
         w_seg_next.b   = '0;
         w_seg_next.dur = DUR_TAIL;
      end
   end

   // Registered segment fields only change on a load, so they hold while
   // pwl_valid is high and pwl_ready is low.
   assign pwl_a   = r_seg.a;
   assign pwl_b   = r_seg.b;
   assign pwl_dur = r_seg.dur;

endmodule
